// File: rtl/proc_io_bus.sv
// Memory-mapped I/O unit for the 16-bit multicycle processor: decodes memory, LEDs,
// synchronized switches and a prescaled countdown timer, with one-cycle read latency.
module proc_io_bus #(
    parameter int PRESCALE = 50000
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [15:0] ADDR,
    input  logic [15:0] DOUT,
    input  logic        W,
    output logic [15:0] DIN,
    input  logic [15:0] mem_q,
    output logic        mem_wren,
    input  logic [9:0]  SW,
    output logic [9:0]  LEDR,
    output logic        timer_to
);
    localparam logic [15:0] PRE_RELOAD = 16'(PRESCALE - 1);

    logic [3:0]  region;
    logic [3:0]  sel_q;
    logic [15:0] io_q;
    logic [15:0] io_rd;
    logic [9:0]  sw_meta;
    logic [9:0]  sw_sync;

    logic        running;
    logic        cont;
    logic        to;
    logic [15:0] load;
    logic [15:0] count;
    logic [15:0] prescaler;

    logic        wr_led;
    logic        wr_ctrl;
    logic        wr_load;
    logic        start;
    logic        stop;
    logic        clrto;
    logic        tick;
    logic        expire;
    logic        unused_addr;

    assign region      = ADDR[15:12];
    assign unused_addr = &{1'b0, ADDR[11:2]};

    assign mem_wren = W & (region == 4'h0);
    assign wr_led   = W & (region == 4'h1);
    assign wr_ctrl  = W & (region == 4'h3) & (ADDR[1:0] == 2'd0);
    assign wr_load  = W & (region == 4'h3) & (ADDR[1:0] == 2'd1);
    assign start    = wr_ctrl & DOUT[0];
    assign stop     = wr_ctrl & DOUT[2];
    assign clrto    = wr_ctrl & DOUT[3];

    assign tick     = running & (prescaler == 16'd0);
    assign expire   = tick & (count == 16'd0);

    always_comb begin
        io_rd = 16'h0000;
        case (region)
            4'h1: io_rd = {6'b0, LEDR};
            4'h2: io_rd = {6'b0, sw_sync};
            4'h3: begin
                case (ADDR[1:0])
                    2'd0:    io_rd = {13'b0, cont, running, to};
                    2'd1:    io_rd = load;
                    2'd2:    io_rd = count;
                    default: io_rd = 16'h0000;
                endcase
            end
            default: io_rd = 16'h0000;
        endcase
    end

    // Read data is registered so every region matches the memory's one-cycle latency.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sel_q   <= 4'h0;
            io_q    <= 16'h0000;
            sw_meta <= 10'h000;
            sw_sync <= 10'h000;
            LEDR    <= 10'h000;
        end else begin
            sel_q   <= region;
            io_q    <= io_rd;
            sw_meta <= SW;
            sw_sync <= sw_meta;
            if (wr_led)
                LEDR <= DOUT[9:0];
        end
    end

    assign DIN = (sel_q == 4'h0) ? mem_q : io_q;

    // A timeout set beats a same-cycle CLRTO; a START beats the tick's count update.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            running   <= 1'b0;
            cont      <= 1'b0;
            to        <= 1'b0;
            load      <= 16'h0000;
            count     <= 16'h0000;
            prescaler <= 16'h0000;
        end else begin
            if (wr_ctrl)
                cont <= DOUT[1];
            if (wr_load)
                load <= DOUT;
            if (expire)
                to <= 1'b1;
            else if (clrto)
                to <= 1'b0;

            if (start) begin
                count     <= load;
                prescaler <= PRE_RELOAD;
                running   <= 1'b1;
            end else if (stop) begin
                running <= 1'b0;
            end else if (running) begin
                if (tick) begin
                    prescaler <= PRE_RELOAD;
                    if (count != 16'd0)
                        count <= count - 16'd1;
                    else if (cont)
                        count <= load;
                    else
                        running <= 1'b0;
                end else begin
                    prescaler <= prescaler - 16'd1;
                end
            end
        end
    end

    assign timer_to = to;

endmodule

// File: tb/tb_proc_io_bus.sv
// Directed bench for proc_io_bus with a 4-cycle prescaler so timer periods stay short.
module tb_proc_io_bus;
    logic        Clock;
    logic        Resetn;
    logic [15:0] ADDR;
    logic [15:0] DOUT;
    logic        W;
    logic [15:0] DIN;
    logic [15:0] mem_q;
    logic        mem_wren;
    logic [9:0]  SW;
    logic [9:0]  LEDR;
    logic        timer_to;

    int checks;
    int failures;

    proc_io_bus #(.PRESCALE(4)) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .ADDR     (ADDR),
        .DOUT     (DOUT),
        .W        (W),
        .DIN      (DIN),
        .mem_q    (mem_q),
        .mem_wren (mem_wren),
        .SW       (SW),
        .LEDR     (LEDR),
        .timer_to (timer_to)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        ADDR = a;
        DOUT = d;
        W    = 1'b1;
        cyc(1);
        W    = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        ADDR = a;
        W    = 1'b0;
        cyc(1);
        d = DIN;
    endtask

    task automatic test_reset;
        Resetn = 1'b0;
        ADDR   = 16'h0000;
        DOUT   = 16'h0000;
        W      = 1'b0;
        mem_q  = 16'h0000;
        SW     = 10'h000;
        #1;
        checks++;
        if (DIN !== 16'h0000 || LEDR !== 10'h000 || timer_to !== 1'b0 || mem_wren !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: DIN=%h LEDR=%h to=%b wren=%b, need 0/0/0/0", DIN, LEDR, timer_to, mem_wren);
        end
        cyc(2);
        Resetn = 1'b1;
        cyc(1);
    endtask

    task automatic test_led;
        logic [15:0] d;
        wr(16'h1000, 16'hFFFF);
        checks++;
        if (LEDR !== 10'h3FF) begin
            failures++;
            $display("FAIL led_write: LEDR=%h need 3ff", LEDR);
        end
        rd(16'h1000, d);
        checks++;
        if (d !== 16'h03FF) begin
            failures++;
            $display("FAIL led_read: DIN=%h need 03ff", d);
        end
    endtask

    task automatic test_mem;
        logic [15:0] d;
        ADDR = 16'h0005;
        DOUT = 16'h1234;
        W    = 1'b1;
        #1;
        checks++;
        if (mem_wren !== 1'b1) begin
            failures++;
            $display("FAIL mem_wren_on: wren=%b need 1", mem_wren);
        end
        ADDR = 16'h2000;
        #1;
        checks++;
        if (mem_wren !== 1'b0) begin
            failures++;
            $display("FAIL mem_wren_off: wren=%b need 0", mem_wren);
        end
        W = 1'b0;
        ADDR = 16'h0005;
        #1;
        checks++;
        if (mem_wren !== 1'b0) begin
            failures++;
            $display("FAIL mem_wren_read: wren=%b need 0", mem_wren);
        end
        mem_q = 16'hBEEF;
        rd(16'h0005, d);
        checks++;
        if (d !== 16'hBEEF) begin
            failures++;
            $display("FAIL mem_read: DIN=%h need beef", d);
        end
        rd(16'h8000, d);
        checks++;
        if (d !== 16'h0000) begin
            failures++;
            $display("FAIL unmapped_read: DIN=%h need 0000", d);
        end
        wr(16'h8000, 16'h0000);
        checks++;
        if (LEDR !== 10'h3FF || mem_wren !== 1'b0) begin
            failures++;
            $display("FAIL unmapped_write: LEDR=%h wren=%b need 3ff/0", LEDR, mem_wren);
        end
        mem_q = 16'h0000;
    endtask

    task automatic test_switch;
        logic [15:0] d;
        ADDR = 16'h2000;
        W    = 1'b0;
        cyc(1);
        SW = 10'h2AA;
        cyc(2);
        checks++;
        if (DIN !== 16'h0000) begin
            failures++;
            $display("FAIL sw_too_early: DIN=%h need 0000 two cycles after change", DIN);
        end
        cyc(1);
        checks++;
        if (DIN !== 16'h02AA) begin
            failures++;
            $display("FAIL sw_read: DIN=%h need 02aa", DIN);
        end
        wr(16'h2000, 16'hFFFF);
        rd(16'h2000, d);
        checks++;
        if (d !== 16'h02AA || LEDR !== 10'h3FF) begin
            failures++;
            $display("FAIL sw_write_ignored: DIN=%h LEDR=%h need 02aa/3ff", d, LEDR);
        end
        rd(16'h3000, d);
        checks++;
        if (d !== 16'h0000) begin
            failures++;
            $display("FAIL sw_write_ctrl: CTRL=%h need 0000", d);
        end
    endtask

    task automatic test_oneshot;
        logic [15:0] d;
        int rise;
        wr(16'h3001, 16'h0003);
        rd(16'h3001, d);
        checks++;
        if (d !== 16'h0003) begin
            failures++;
            $display("FAIL load_read: LOAD=%h need 0003", d);
        end
        wr(16'h3000, 16'h0001);
        rise = 0;
        for (int k = 1; k <= 40; k++) begin
            cyc(1);
            if (timer_to === 1'b1 && rise == 0)
                rise = k;
        end
        checks++;
        if (rise != 16) begin
            failures++;
            $display("FAIL oneshot_period: to rose at +%0d need +16", rise);
        end
        rd(16'h3000, d);
        checks++;
        if (d !== 16'h0001) begin
            failures++;
            $display("FAIL oneshot_ctrl: CTRL=%h need 0001", d);
        end
        rd(16'h3002, d);
        checks++;
        if (d !== 16'h0000) begin
            failures++;
            $display("FAIL oneshot_count: COUNT=%h need 0000", d);
        end
    endtask

    task automatic test_cont;
        logic [15:0] d;
        wr(16'h3000, 16'h0008);
        checks++;
        if (timer_to !== 1'b0) begin
            failures++;
            $display("FAIL clrto: to=%b need 0", timer_to);
        end
        wr(16'h3001, 16'h0001);
        wr(16'h3000, 16'h0003);
        ADDR = 16'h3000;
        DOUT = 16'h000A;
        // CLRTO writes land on edges +9, +17 and +24 (the last coincides with a timeout)
        for (int k = 1; k <= 24; k++) begin
            W = (k == 9 || k == 17 || k == 24);
            cyc(1);
            W = 1'b0;
            if (k == 7 || k == 9 || k == 15 || k == 17 || k == 23) begin
                checks++;
                if (timer_to !== 1'b0) begin
                    failures++;
                    $display("FAIL cont_low_%0d: to=%b need 0", k, timer_to);
                end
            end
            if (k == 8 || k == 16 || k == 24) begin
                checks++;
                if (timer_to !== 1'b1) begin
                    failures++;
                    $display("FAIL cont_high_%0d: to=%b need 1", k, timer_to);
                end
            end
        end
        rd(16'h3000, d);
        checks++;
        if (d !== 16'h0007) begin
            failures++;
            $display("FAIL cont_ctrl: CTRL=%h need 0007", d);
        end
        wr(16'h3000, 16'h0004);
        rd(16'h3000, d);
        checks++;
        if (d !== 16'h0001) begin
            failures++;
            $display("FAIL stop_ctrl: CTRL=%h need 0001", d);
        end
    endtask

    task automatic test_midreset;
        logic [15:0] d;
        wr(16'h1000, 16'h0155);
        wr(16'h3001, 16'h0005);
        wr(16'h3000, 16'h0001);
        cyc(6);
        rd(16'h1000, d);
        checks++;
        if (d !== 16'h0155 || timer_to !== 1'b1) begin
            failures++;
            $display("FAIL prereset: DIN=%h to=%b need 0155/1", d, timer_to);
        end
        #2;
        Resetn = 1'b0;
        #1;
        checks++;
        if (DIN !== 16'h0000 || LEDR !== 10'h000 || timer_to !== 1'b0 || mem_wren !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: DIN=%h LEDR=%h to=%b wren=%b need 0/0/0/0", DIN, LEDR, timer_to, mem_wren);
        end
        cyc(1);
        Resetn = 1'b1;
        rd(16'h3000, d);
        checks++;
        if (d !== 16'h0000) begin
            failures++;
            $display("FAIL reset_ctrl: CTRL=%h need 0000", d);
        end
        rd(16'h3002, d);
        checks++;
        if (d !== 16'h0000) begin
            failures++;
            $display("FAIL reset_count: COUNT=%h need 0000", d);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset;
        test_led;
        test_mem;
        test_switch;
        test_oneshot;
        test_cont;
        test_midreset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
